// File: rtl/clock_gating_cell.sv
// Latch-based integrated clock-gating cell with test override, reset clock-force
// and a saturating counter of delivered gated-clock pulses.
module clock_gating_cell #(
    parameter int unsigned CNT_W      = 16,
    parameter bit          RST_CLK_ON = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             test_en,
    output logic             clock_out,
    output logic             en_latched,
    output logic [CNT_W-1:0] pulse_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             en_eff_s;
    logic             en_latch_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign en_eff_s = clk_en | test_en | (RST_CLK_ON & rst);

    // Enable latch: transparent in the low phase so the gate can only open or close
    // while clk_in is low, which keeps every clock_out high pulse full-width.
    always_latch begin
        if (!clk_in) begin
            en_latch_q <= en_eff_s;
        end
    end

    assign en_latched = en_latch_q;
    assign clock_out  = clk_in & en_latch_q;

    // Next count: one more for each delivered pulse, sticking at the top value.
    always_comb begin
        cnt_d = cnt_q;
        if (en_latch_q) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pulse counter register with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_clock_gating_cell.sv
// Randomised self-checking bench for clock_gating_cell: three instances (default,
// 4-bit counter, no reset clock-force) checked against a cycle-level reference model.
module tb_clock_gating_cell;

    localparam int HALF = 5;

    logic clk_in  = 1'b0;
    logic rst     = 1'b1;
    logic clk_en  = 1'b0;
    logic test_en = 1'b0;

    logic        a_clk, a_en;
    logic [15:0] a_cnt;
    logic        s_clk, s_en;
    logic [3:0]  s_cnt;
    logic        n_clk, n_en;
    logic [3:0]  n_cnt;

    clock_gating_cell #(.CNT_W(16), .RST_CLK_ON(1'b1)) dut_a (
        .clk_in(clk_in), .rst(rst), .clk_en(clk_en), .test_en(test_en),
        .clock_out(a_clk), .en_latched(a_en), .pulse_cnt(a_cnt));
    clock_gating_cell #(.CNT_W(4), .RST_CLK_ON(1'b1)) dut_s (
        .clk_in(clk_in), .rst(rst), .clk_en(clk_en), .test_en(test_en),
        .clock_out(s_clk), .en_latched(s_en), .pulse_cnt(s_cnt));
    clock_gating_cell #(.CNT_W(4), .RST_CLK_ON(1'b0)) dut_n (
        .clk_in(clk_in), .rst(rst), .clk_en(clk_en), .test_en(test_en),
        .clock_out(n_clk), .en_latched(n_en), .pulse_cnt(n_cnt));

    always #HALF clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Observed gated-clock rising edges and high-pulse widths per instance.
    int  edges [3];
    time rise_t [3];
    bit  rose [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            edges[i] = 0;
            rose[i]  = 1'b0;
        end
    end

    always @(posedge a_clk) begin edges[0]++; rise_t[0] = $time; rose[0] = 1'b1; end
    always @(posedge s_clk) begin edges[1]++; rise_t[1] = $time; rose[1] = 1'b1; end
    always @(posedge n_clk) begin edges[2]++; rise_t[2] = $time; rose[2] = 1'b1; end
    always @(negedge a_clk) if (rose[0]) check_eq("width_a", 32'($time - rise_t[0]), 32'(HALF));
    always @(negedge s_clk) if (rose[1]) check_eq("width_s", 32'($time - rise_t[1]), 32'(HALF));
    always @(negedge n_clk) if (rose[2]) check_eq("width_n", 32'($time - rise_t[2]), 32'(HALF));

    // Reference model: counts of delivered pulses per instance.
    int       m_cnt [3];
    int       m_max [3] = '{65535, 15, 15};
    bit       m_frc [3] = '{1'b1, 1'b1, 1'b0};

    // One clk_in period: inputs set in the low phase, optionally a clk_en glitch
    // inside the high phase that must not reach the gated clock.
    task automatic cycle(input bit en, input bit te, input bit rs, input bit glitch);
        int  e0 [3];
        bit  pulse [3];
        @(negedge clk_in);
        #1;
        clk_en  = en;
        test_en = te;
        rst     = rs;
        for (int i = 0; i < 3; i++) e0[i] = edges[i];
        @(posedge clk_in);
        for (int i = 0; i < 3; i++) begin
            pulse[i] = en | te | (m_frc[i] & rs);
            if (rs)                              m_cnt[i] = 0;
            else if (pulse[i] && m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
        end
        #1;
        check_eq("edges_a", 32'(edges[0] - e0[0]), 32'(pulse[0]));
        check_eq("edges_s", 32'(edges[1] - e0[1]), 32'(pulse[1]));
        check_eq("edges_n", 32'(edges[2] - e0[2]), 32'(pulse[2]));
        check_eq("en_a", 32'(a_en), 32'(pulse[0]));
        check_eq("en_n", 32'(n_en), 32'(pulse[2]));
        check_eq("cnt_a", 32'(a_cnt), 32'(m_cnt[0]));
        check_eq("cnt_s", 32'(s_cnt), 32'(m_cnt[1]));
        check_eq("cnt_n", 32'(n_cnt), 32'(m_cnt[2]));
        if (glitch) begin
            #1 clk_en = ~en;
            #1;
            check_eq("glitch_lvl_a", 32'(a_clk), 32'(pulse[0]));
            check_eq("glitch_lvl_n", 32'(n_clk), 32'(pulse[2]));
            #1 clk_en = en;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;

        // Reset with clock forced, then five enabled cycles.
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("after_enable_a", 32'(a_cnt), 32'd5);

        // Disabled: gate stays closed, count holds.
        repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("hold_a", 32'(a_cnt), 32'd5);
        check_eq("closed_en_a", 32'(a_en), 32'd0);

        // High-phase enable glitches must not produce pulses.
        repeat (8) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("glitch_hold_a", 32'(a_cnt), 32'd5);

        // Test override.
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("override_a", 32'(a_cnt), 32'd9);

        // Saturation of the 4-bit counters.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (20) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("sat_s", 32'(s_cnt), 32'd15);

        // Reset with enable: clock delivered, counters held at zero.
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("rst_en_n", 32'(n_cnt), 32'd0);

        // Randomised traffic, including glitches and occasional reset.
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
                  1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_gating_cell.md
Name: clock_gating_cell

Overview:
- Glitch-free integrated clock-gating cell (ICG) with a latch-based enable. It drives gated clocks for sampling registers, e.g. the hypotenuse sampling flop fed by the enable condition "not overflow, sides non-zero, not reset, sqrt not busy".
- Adds a scan/test override and a reset clock-force, so downstream synchronous resets always take effect.
- Adds a saturating counter of delivered clock pulses, used for verification and power accounting.

Parameters:
- CNT_W, 16, width of the delivered-pulse counter.
- RST_CLK_ON, 1, when 1 the gated clock runs while rst=1; when 0, rst has no effect on gating.

Ports:
- clk_in  input  1  free-running source clock; the only clock.
- rst  input  1  synchronous, active-high reset, sampled on clk_in rising edge.
- clk_en  input  1  functional clock enable, sourced from clk_in-domain logic.
- test_en  input  1  scan/test override; 1 forces the clock on.
- clock_out  output  1  gated clock.
- en_latched  output  1  current value of the enable latch (observability).
- pulse_cnt  output  CNT_W  number of clock_out rising edges delivered since reset; saturating.

Behaviour:
- Effective enable: en_eff = clk_en | test_en | (RST_CLK_ON & rst).
- Enable latch: level-sensitive latch, transparent while clk_in=0, holding while clk_in=1.
- Latch output: en_latched. Gated clock: clock_out = clk_in & en_latched. Implement as one AND gate; no flop in the clock path.
- Glitch freedom:
  - en_eff changes while clk_in=1 have no effect until clk_in next goes low.
  - clock_out never produces a partial high pulse; every high pulse equals a full clk_in high phase.
- Latency:
  - en_eff=1 stable before a clk_in rising edge passes that same edge to clock_out (zero-cycle latency).
  - Deassertion before a rising edge suppresses that edge.
  - Enable is a setup-to-rising-edge requirement: en_eff must be stable during the low phase preceding the edge.
- X/initial state: en_latched powers up unknown. Simulation models must initialise it to 0, so clock_out=0 before the first low phase resolves.
- pulse_cnt: register clocked on clk_in rising edge.
  - If rst=1: clears to 0.
  - Else if en_latched=1 at that edge (a clock_out pulse is issued): increments by 1, saturating at 2^CNT_W-1 with no wrap.
  - Else: holds.
- Reset values:
  - pulse_cnt=0 after the first rising edge with rst=1.
  - en_latched and clock_out follow en_eff. With RST_CLK_ON=1, clock_out toggles with clk_in throughout reset.
- Reset mid-operation: rst clears pulse_cnt on the next edge regardless of clk_en. It does not stop clock_out when RST_CLK_ON=1.
- Simultaneous rst and clk_en=1: reset wins for the counter; the clock is delivered.
- test_en=1: clock_out equals clk_in; counter counts normally.
- Outputs are combinational from the latch (clock_out, en_latched) or registered (pulse_cnt). No other state.

Test Plan:
- Reset and enable: RST_CLK_ON=1; rst=1 for 3 edges, clk_en=0 -> 3 clock_out pulses, pulse_cnt=0. Then rst=0, clk_en=1 for 5 edges -> 5 pulses, pulse_cnt=5.
- Disable: clk_en=0 for 10 cycles, test_en=0, rst=0 -> clock_out stuck 0, en_latched=0, pulse_cnt holds 5.
- Glitch check: toggle clk_en 0->1->0 entirely within clk_in high phases for 8 cycles -> clock_out stays 0, no pulse narrower than the clk_in high time, pulse_cnt unchanged.
- Test override: clk_en=0, test_en=1 for 4 cycles -> clock_out equals clk_in, pulse_cnt +4.
- Saturation: CNT_W=4, clk_en=1 for 20 cycles after reset -> pulse_cnt reaches 15 and holds 15.
- RST_CLK_ON=0: rst=1, clk_en=0 for 3 edges -> no clock_out pulses, pulse_cnt=0. Then rst=1 with clk_en=1 -> pulses delivered, pulse_cnt stays 0.
